// File: rtl/gray_enc_pkg.sv
// Shared definitions for the one-hot to Gray encoder.
//   IN_W        : one-hot input width (16)
//   OUT_W       : Gray / index width (4)
//   ERR_MAX     : saturation value of the error counter
//   ILLEGAL_BIT : the input bit that never maps to a legal code
//   s1_payload_t: first pipeline stage payload {index, err}
//   bin2gray    : binary to reflected Gray conversion
package gray_enc_pkg;

  localparam int         IN_W        = 16;
  localparam int         OUT_W       = 4;
  localparam logic [7:0] ERR_MAX     = 8'hFF;
  localparam int         ILLEGAL_BIT = 15;

  typedef struct packed {
    logic [OUT_W-1:0] index;
    logic             err;
  } s1_payload_t;

  function automatic logic [OUT_W-1:0] bin2gray(input logic [OUT_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/onehot_index_detect.sv
// Combinational front end of the encoder: turns a one-hot word into the
// binary code index that the Gray conversion consumes.
//   in_data : 16-bit one-hot word
//   index   : 0 for an all-zero word, i+1 for bit i (i in 0..14), 0 on error
//   err     : word is illegal (bit 15 set, or multi-hot in the default build)
// Build option: define GRAY_ENC_PRIORITY_EN to resolve multi-hot words to the
// highest set bit among 0..14 instead of flagging them.
module onehot_index_detect
  import gray_enc_pkg::*;
(
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] index,
  output logic             err
);

  logic [OUT_W-1:0] hi_idx;

  // Scanning upward leaves the highest set bit; for a true one-hot word that
  // is simply its only bit.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < ILLEGAL_BIT; i++) begin
      if (in_data[i]) hi_idx = OUT_W'(i + 1);
    end
  end

`ifdef GRAY_ENC_PRIORITY_EN
  assign err = in_data[ILLEGAL_BIT];
`else
  logic multi_hot;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(in_data & (in_data - IN_W'(1)));
  assign err       = in_data[ILLEGAL_BIT] | multi_hot;
`endif

  // Illegal words encode as code 0 so the Gray output reads 0000.
  assign index = err ? '0 : hi_idx;

endmodule

// File: rtl/onehot_to_gray_encoder.sv
// Two-stage pipelined one-hot to Gray encoder with valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/in_valid     : one-hot word and its qualifier
//   in_ready             : word is accepted this cycle (no output stall)
//   out_gray/out_err     : encoded Gray value and illegal-word flag
//   out_valid/out_ready  : output qualifier and downstream acceptance
//   err_count            : saturating count of illegal words handed off
//   clr_err_cnt          : synchronous clear of err_count (wins over increment)
// Build option: GRAY_ENC_PRIORITY_EN (see onehot_index_detect).
module onehot_to_gray_encoder #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_W-1:0]     out_gray,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err_cnt
);

  import gray_enc_pkg::*;

  logic             stall;
  logic [OUT_W-1:0] det_index;
  logic             det_err;

  s1_payload_t          s1_q, s1_d;
  logic                 v1_q, v1_d;
  logic [OUT_W-1:0]     out_gray_q, out_gray_d;
  logic                 out_err_q, out_err_d;
  logic                 out_valid_q, out_valid_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  onehot_index_detect u_detect (
    .in_data (in_data),
    .index   (det_index),
    .err     (det_err)
  );

  // The whole pipeline moves as one: a held output freezes both stages.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    s1_d        = s1_q;
    v1_d        = v1_q;
    out_gray_d  = out_gray_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    if (!stall) begin
      v1_d = in_valid;
      // Bubbles carry a zero payload so they can never look like errors.
      s1_d = in_valid ? '{index: det_index, err: det_err} : '0;
      out_valid_d = v1_q;
      out_err_d   = v1_q & s1_q.err;
      out_gray_d  = v1_q ? bin2gray(s1_q.index) : '0;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (clr_err_cnt) begin
      err_count_d = '0;
    end else if (out_valid_q && out_ready && out_err_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      v1_q        <= 1'b0;
      out_gray_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_q        <= s1_d;
      v1_q        <= v1_d;
      out_gray_q  <= out_gray_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_gray  = out_gray_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_onehot_to_gray_encoder.sv
// Self-checking bench for onehot_to_gray_encoder. Accepted words are pushed
// to an expected queue with their model result; output handshakes are pushed
// to an observed queue; each scenario task compares the two in order.
module tb_onehot_to_gray_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  out_gray;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  err_count;
  logic        clr_err_cnt = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  gray;
    logic        err;
    int          cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  onehot_to_gray_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_gray    (out_gray),
    .out_err     (out_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_count   (err_count),
    .clr_err_cnt (clr_err_cnt)
  );

  // Reference: returns {err, gray}.
  function automatic logic [4:0] model(input logic [15:0] d);
    int         cnt = 0;
    int         top = -1;
    logic [3:0] n;
    for (int i = 0; i < 15; i++) begin
      if (d[i]) begin
        cnt++;
        top = i;
      end
    end
    if (d[15]) return 5'b1_0000;
`ifndef GRAY_ENC_PRIORITY_EN
    if (cnt > 1) return 5'b1_0000;
`endif
    if (top < 0) return 5'b0_0000;
    n = 4'(top + 1);
    return {1'b0, n ^ (n >> 1)};
  endfunction

  // One clock: record handshakes as they will happen at the coming edge.
  task automatic tick();
    logic [4:0] m;
    #1;
    if (in_valid && in_ready) begin
      m = model(in_data);
      exp_q.push_back('{in_data, m[3:0], m[4], cyc});
    end
    if (out_valid && out_ready) begin
      obs_q.push_back('{16'h0, out_gray, out_err, cyc});
      $display("cyc %0d: out gray=%b err=%0d err_count=%0d", cyc, out_gray, out_err, err_count);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && obs_q.size() < exp_q.size(); k++) tick();
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || out_gray !== 4'b0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b err=%b gray=%b cnt=%0d, want 0/0/0000/0",
               out_valid, out_err, out_gray, err_count);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_legal();
    rec_t       e, o;
    logic [3:0] b;
    logic [15:0] dec;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 16'h0000 : (16'(1) << (i - 1));
      tick();
    end
    drain();
    vectors++;
    if (obs_q.size() != 16 || exp_q.size() != 16) begin
      miscompares++;
      $display("FAIL legal_count: got %0d outputs for %0d accepted, want 16/16", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o.gray !== e.gray || o.err !== e.err) begin
        miscompares++;
        $display("FAIL legal_code in=%h: got gray=%b err=%b want gray=%b err=%b", e.data, o.gray, o.err, e.gray, e.err);
      end
      vectors++;
      if (o.cyc - e.cyc != 2) begin
        miscompares++;
        $display("FAIL legal_latency in=%h: got %0d cycles want 2", e.data, o.cyc - e.cyc);
      end
      b[3] = o.gray[3];
      for (int k = 2; k >= 0; k--) b[k] = b[k+1] ^ o.gray[k];
      dec = (b == 4'd0) ? 16'h0000 : (16'(1) << (b - 4'd1));
      vectors++;
      if (dec !== e.data) begin
        miscompares++;
        $display("FAIL legal_roundtrip: got %h want %h", dec, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_illegal();
    rec_t        e, o;
    logic [15:0] words [2];
    words[0] = 16'h0005;
    words[1] = 16'h8000;
    for (int w = 0; w < 2; w++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = words[w];
      tick();
      drain();
      vectors++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
        miscompares++;
        $display("FAIL illegal_count in=%h: got %0d outputs for %0d accepted, want 1/1", words[w], obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        vectors++;
        if (o.gray !== e.gray || o.err !== e.err) begin
          miscompares++;
          $display("FAIL illegal_code in=%h: got gray=%b err=%b want gray=%b err=%b", e.data, o.gray, o.err, e.gray, e.err);
        end
        if (e.err) exp_cnt++;
      end
      exp_q.delete();
      obs_q.delete();
      vectors++;
      if (err_count !== 8'(exp_cnt)) begin
        miscompares++;
        $display("FAIL illegal_err_count in=%h: got %0d want %0d", words[w], err_count, exp_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    rec_t        e, o;
    logic [15:0] w [3];
    int          idx = 0;
    int          stalls = 0;
    int          n;
    w[0] = 16'h0002;
    w[1] = 16'h0010;
    w[2] = 16'h0400;
    out_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (idx < 3) begin
        in_valid = 1'b1;
        in_data  = w[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready && stalls < 4 && exp_q.size() > 0) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_in_ready stall %0d: got %b want 0", stalls, in_ready);
        end
        vectors++;
        if (out_gray !== exp_q[0].gray) begin
          miscompares++;
          $display("FAIL bp_hold stall %0d: got %b want %b", stalls, out_gray, exp_q[0].gray);
        end
        stalls++;
        if (stalls == 4) out_ready = 1'b1;
      end
      n = exp_q.size();
      tick();
      if (exp_q.size() > n) idx++;
      if (idx == 3 && obs_q.size() >= 3 && !out_valid) break;
    end
    vectors++;
    if (stalls != 4 || obs_q.size() != 3 || exp_q.size() != 3) begin
      miscompares++;
      $display("FAIL bp_count: got stalls=%0d outputs=%0d accepted=%0d want 4/3/3", stalls, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < 3 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (e.data !== w[i] || o.gray !== e.gray || o.err !== e.err) begin
        miscompares++;
        $display("FAIL bp_order %0d: got in=%h gray=%b err=%b want in=%h gray=%b err=%b",
                 i, e.data, o.gray, o.err, w[i], e.gray, e.err);
      end
    end
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b1;
  endtask

  task automatic test_saturation();
    rec_t e, o;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h8000;
    for (int i = 0; i < 260; i++) tick();
    drain();
    vectors++;
    if (obs_q.size() != 260) begin
      miscompares++;
      $display("FAIL sat_count: got %0d outputs want 260", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (e.err && exp_cnt < 255) exp_cnt++;
      vectors++;
      if (o.gray !== e.gray || o.err !== e.err) begin
        miscompares++;
        $display("FAIL sat_code: got gray=%b err=%b want gray=%b err=%b", o.gray, o.err, e.gray, e.err);
      end
    end
    exp_q.delete();
    obs_q.delete();
    vectors++;
    if (err_count !== 8'(exp_cnt) || exp_cnt != 255) begin
      miscompares++;
      $display("FAIL sat_value: got %0d want 255", err_count);
    end
    // Park an error word at the output, then clear on its handshake cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h8000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_err !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_setup: got valid=%b err=%b want 1/1", out_valid, out_err);
    end
    clr_err_cnt = 1'b1;
    out_ready   = 1'b1;
    tick();
    clr_err_cnt = 1'b0;
    exp_cnt     = 0;
    vectors++;
    if (err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL clr_priority: got %0d want 0", err_count);
    end
    vectors++;
    if (obs_q.size() != 1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_handshake: got %0d outputs valid=%b want 1 output valid=0", obs_q.size(), out_valid);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0005;
    tick();
    drain();
    in_valid = 1'b1;
    in_data  = 16'h8000;
    tick();
    drain();
    exp_q.delete();
    obs_q.delete();
    exp_cnt = 1;
`ifndef GRAY_ENC_PRIORITY_EN
    exp_cnt = 2;
`endif
    vectors++;
    if (err_count !== 8'(exp_cnt)) begin
      miscompares++;
      $display("FAIL rst_pre_count: got %0d want %0d", err_count, exp_cnt);
    end
    in_valid = 1'b1;
    in_data  = 16'h8000;
    tick();
    in_data = 16'h0008;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got valid=%b cnt=%0d err=%b want 0/0/0", out_valid, err_count, out_err);
    end
    exp_q.delete();
    obs_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (obs_q.size() != 0 || err_count !== 8'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_stale: got %0d outputs cnt=%0d in_ready=%b want 0/0/1", obs_q.size(), err_count, in_ready);
    end
    obs_q.delete();
  endtask

  task automatic test_bubbles();
    rec_t e, o;
    logic iv [12];
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      iv[t]    = (t % 2 == 0);
      in_valid = iv[t];
      // Bubbles carry an illegal pattern that must never be counted.
      in_data  = iv[t] ? (16'(1) << (t % 15)) : 16'h8000;
      #1;
      if (t >= 2) begin
        vectors++;
        if (out_valid !== iv[t-2]) begin
          miscompares++;
          $display("FAIL bubble_valid t=%0d: got %b want %b", t, out_valid, iv[t-2]);
        end
      end
      tick();
    end
    drain();
    vectors++;
    if (obs_q.size() != 6 || exp_q.size() != 6) begin
      miscompares++;
      $display("FAIL bubble_count: got %0d outputs for %0d accepted, want 6/6", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o.gray !== e.gray || o.err !== e.err) begin
        miscompares++;
        $display("FAIL bubble_code in=%h: got gray=%b err=%b want gray=%b err=%b", e.data, o.gray, o.err, e.gray, e.err);
      end
    end
    vectors++;
    if (err_count !== 8'(exp_cnt)) begin
      miscompares++;
      $display("FAIL bubble_err_count: got %0d want %0d", err_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    test_bubbles();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
